// File: rtl/motor_controller_core_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words and
// compares them against build-time constants, with a per-phase read timeout.
module motor_controller_core_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h20140830,
  parameter logic [31:0] EXPECTED_TS    = 32'h5400E662,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        avm_address_o,
  output logic        avm_read_o,
  input  logic        avm_waitrequest_i,
  input  logic        avm_readdatavalid_i,
  input  logic [31:0] avm_readdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [31:0] id_value_o,
  output logic [31:0] ts_value_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    StIdle,
    StReqId,
    StRspId,
    StReqTs,
    StRspTs,
    StFinish
  } state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic        auto_q, auto_d;

  logic is_req;
  logic phase_ts;
  logic complete;

  assign is_req   = (state_q == StReqId) || (state_q == StReqTs);
  assign phase_ts = (state_q == StReqTs) || (state_q == StRspTs);
  // Data may return in the accept cycle of the request itself.
  assign complete = avm_readdatavalid_i &&
                    ((state_q == StRspId) || (state_q == StRspTs) ||
                     (is_req && !avm_waitrequest_i));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    ts_d          = ts_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    auto_d        = auto_q;
    avm_read_o    = 1'b0;
    avm_address_o = 1'b0;
    done_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i || auto_q) begin
          state_d   = StReqId;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          auto_d    = 1'b0;
        end
      end
      StReqId, StRspId, StReqTs, StRspTs: begin
        avm_read_o    = is_req;
        avm_address_o = phase_ts;
        cnt_d         = cnt_q + 16'd1;
        if (complete) begin
          if (phase_ts) ts_d = avm_readdata_i;
          else          id_d = avm_readdata_i;
          state_d = phase_ts ? StFinish : StReqTs;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else if (is_req && !avm_waitrequest_i) begin
          state_d = phase_ts ? StRspTs : StRspId;
        end
      end
      StFinish: begin
        done_o  = 1'b1;
        pass_d  = !timeout_q && (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      id_q      <= '0;
      ts_q      <= '0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      auto_q    <= auto_d;
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign pass_o     = pass_q;
  assign timeout_o  = timeout_q;
  assign id_value_o = id_q;
  assign ts_value_o = ts_q;

endmodule

// File: tb/tb_motor_controller_core_sysid_checker.sv
// Directed bench: one instance with defaults (auto-start), one with an 8-cycle
// timeout and no auto-start, each fed by a small behavioural ID slave.
module tb_motor_controller_core_sysid_checker;

  localparam logic [31:0] ExpId = 32'h20140830;
  localparam logic [31:0] ExpTs = 32'h5400E662;

  logic        clk = 1'b0;
  logic        rst, rst2, start, start2;
  logic        wreq, rdv, addr, rd, busy, done, pass, tout;
  logic [31:0] rdata, idv, tsv;
  logic        rdv2, addr2, rd2, busy2, done2, pass2, tout2;
  logic [31:0] rdata2, idv2, tsv2;

  int errors = 0;
  int checks = 0;

  // Slave 1 model controls and monitors
  int          wait_n = 0, lat_n = 1, stall = 0, pend = 0;
  int          acc0 = 0, acc1 = 0, addr_err = 0;
  logic        stalled = 1'b0, held_addr = 1'b0, pend_addr = 1'b0;
  logic [31:0] id_word = ExpId, ts_word = ExpTs;

  // Slave 2 model
  logic acc2_prev = 1'b0, acc2_addr = 1'b0, drop2 = 1'b0;
  int   rd2_0 = 0, rd2_1 = 0;

  always #5 clk = ~clk;

  motor_controller_core_sysid_checker dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .start_i             (start),
    .avm_address_o       (addr),
    .avm_read_o          (rd),
    .avm_waitrequest_i   (wreq),
    .avm_readdatavalid_i (rdv),
    .avm_readdata_i      (rdata),
    .busy_o              (busy),
    .done_o              (done),
    .pass_o              (pass),
    .id_value_o          (idv),
    .ts_value_o          (tsv),
    .timeout_o           (tout)
  );

  motor_controller_core_sysid_checker #(
    .TIMEOUT_CYCLES (8),
    .AUTO_START     (1'b0)
  ) dut2 (
    .clock_i             (clk),
    .reset_i             (rst2),
    .start_i             (start2),
    .avm_address_o       (addr2),
    .avm_read_o          (rd2),
    .avm_waitrequest_i   (1'b0),
    .avm_readdatavalid_i (rdv2),
    .avm_readdata_i      (rdata2),
    .busy_o              (busy2),
    .done_o              (done2),
    .pass_o              (pass2),
    .id_value_o          (idv2),
    .ts_value_o          (tsv2),
    .timeout_o           (tout2)
  );

  // Slave 1: wait_n stall cycles per read, data lat_n cycles after accept (0 = same cycle).
  always @(negedge clk) begin
    rdv   = 1'b0;
    rdata = 32'h0;
    wreq  = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        rdv   = 1'b1;
        rdata = pend_addr ? ts_word : id_word;
      end
    end
    if (rst) begin
      stall   = 0;
      stalled = 1'b0;
    end else if (rd) begin
      if (stalled && addr !== held_addr) addr_err++;
      if (stall < wait_n) begin
        wreq      = 1'b1;
        stall++;
        stalled   = 1'b1;
        held_addr = addr;
      end else begin
        stall   = 0;
        stalled = 1'b0;
        if (addr) acc1++;
        else      acc0++;
        if (lat_n == 0) begin
          rdv   = 1'b1;
          rdata = addr ? ts_word : id_word;
        end else begin
          pend      = lat_n;
          pend_addr = addr;
        end
      end
    end
  end

  // Slave 2: never stalls, answers one cycle later unless the ID answer is dropped.
  always @(negedge clk) begin
    rdv2      = acc2_prev && !(drop2 && !acc2_addr);
    rdata2    = acc2_addr ? ExpTs : ExpId;
    acc2_prev = 1'b0;
    if (!rst2 && rd2) begin
      acc2_prev = 1'b1;
      acc2_addr = addr2;
      if (addr2) rd2_1++;
      else       rd2_0++;
    end
  end

  // Returns edges until done (trigger edge = 1) and busy cycles seen; n = -1 on expiry.
  task automatic wait_done(input bit sel, output int n, output int b);
    n = -1;
    b = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start  = 1'b0;
      start2 = 1'b0;
      if (sel ? busy2 : busy) b++;
      if (sel ? done2 : done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd, addr, busy, done, pass, tout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {rd, addr, busy, done, pass, tout});
    end
    checks++;
    if (idv !== 32'h0 || tsv !== 32'h0) begin
      errors++;
      $display("FAIL reset_vals: got id=%h ts=%h want 0/0", idv, tsv);
    end
  endtask

  task automatic test_autostart;
    int n, b;
    rst = 1'b0; rst2 = 1'b0;
    wait_done(1'b0, n, b);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL auto_latency: got %0d want 5", n);
    end
    @(posedge clk); #1;
    checks++;
    if (pass !== 1'b1 || idv !== ExpId || tsv !== ExpTs) begin
      errors++;
      $display("FAIL auto_pass: got pass=%b id=%h ts=%h want 1/%h/%h", pass, idv, tsv, ExpId, ExpTs);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (acc0 !== 1 || acc1 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL auto_reads: got a0=%0d a1=%0d busy=%b want 1/1/0", acc0, acc1, busy);
    end
    checks++;
    if (busy2 !== 1'b0 || rd2_0 !== 0) begin
      errors++;
      $display("FAIL no_autostart: got busy=%b reads=%0d want 0/0", busy2, rd2_0);
    end
  endtask

  task automatic test_bad_ts;
    int n, b;
    ts_word = 32'h5400E663;
    start = 1'b1;
    wait_done(1'b0, n, b);
    checks++;
    if (n !== 5 || b !== 5) begin
      errors++;
      $display("FAIL bad_ts_timing: got n=%0d busy=%0d want 5/5", n, b);
    end
    checks++;
    if (tsv !== 32'h5400E663 || tout !== 1'b0) begin
      errors++;
      $display("FAIL bad_ts_value: got ts=%h to=%b want 5400e663/0", tsv, tout);
    end
    @(posedge clk); #1;
    checks++;
    if (pass !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_ts_pass: got pass=%b done=%b want 0/0", pass, done);
    end
    ts_word = ExpTs;
  endtask

  task automatic test_stall;
    int n, b, a0, a1;
    a0 = acc0; a1 = acc1;
    wait_n = 3; lat_n = 4;
    start = 1'b1;
    wait_done(1'b0, n, b);
    // Per phase: 3 stalled + 1 accept request cycles, 4 response cycles; then FINISH.
    checks++;
    if (n !== 17 || b !== 17) begin
      errors++;
      $display("FAIL stall_timing: got n=%0d busy=%0d want 17/17", n, b);
    end
    checks++;
    if (addr_err !== 0 || acc0 !== a0 + 1 || acc1 !== a1 + 1) begin
      errors++;
      $display("FAIL stall_reads: got aerr=%0d da0=%0d da1=%0d want 0/1/1",
               addr_err, acc0 - a0, acc1 - a1);
    end
    @(posedge clk); #1;
    checks++;
    if (pass !== 1'b1) begin
      errors++;
      $display("FAIL stall_pass: got %b want 1", pass);
    end
    wait_n = 0; lat_n = 1;
  endtask

  task automatic test_zero_latency;
    int n, b;
    lat_n = 0;
    start = 1'b1;
    wait_done(1'b0, n, b);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL zero_lat_timing: got %0d want 3", n);
    end
    @(posedge clk); #1;
    checks++;
    if (pass !== 1'b1 || idv !== ExpId) begin
      errors++;
      $display("FAIL zero_lat_pass: got pass=%b id=%h want 1/%h", pass, idv, ExpId);
    end
    lat_n = 1;
  endtask

  task automatic test_back_to_back;
    int n, b, a0;
    a0 = acc0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, n, b);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL busy_start_timing: got %0d want 2", n);
    end
    @(posedge clk); #1;
    start = 1'b1;
    wait_done(1'b0, n, b);
    checks++;
    if (n !== 5 || acc0 !== a0 + 2) begin
      errors++;
      $display("FAIL after_done_start: got n=%0d da0=%0d want 5/2", n, acc0 - a0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || acc0 !== a0 + 2) begin
      errors++;
      $display("FAIL finish_start: got busy=%b da0=%0d want 0/2", busy, acc0 - a0);
    end
  endtask

  task automatic test_reset_mid;
    int n, b;
    bit found;
    found = 1'b0;
    lat_n = 4;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (addr && !rd && busy) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (!found || rd !== 1'b0 || busy !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got found=%b rd=%b busy=%b pass=%b want 1/0/0/0",
               found, rd, busy, pass);
    end
    repeat (6) @(posedge clk);
    #1;
    lat_n = 1;
    rst = 1'b0;
    wait_done(1'b0, n, b);
    @(posedge clk); #1;
    checks++;
    if (n !== 5 || pass !== 1'b1) begin
      errors++;
      $display("FAIL reset_restart: got n=%0d pass=%b want 5/1", n, pass);
    end
  endtask

  task automatic test_timeout;
    int n, b;
    drop2 = 1'b1;
    start2 = 1'b1;
    wait_done(1'b1, n, b);
    // REQ_ID entered on trigger edge; 8 cycles allowed, FINISH on the 9th edge.
    checks++;
    if (n !== 9 || tout2 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_timing: got n=%0d to=%b want 9/1", n, tout2);
    end
    checks++;
    if (idv2 !== 32'h0 || tsv2 !== 32'h0 || rd2_1 !== 0 || rd2_0 !== 1) begin
      errors++;
      $display("FAIL timeout_reads: got id=%h ts=%h r0=%0d r1=%0d want 0/0/1/0",
               idv2, tsv2, rd2_0, rd2_1);
    end
    @(posedge clk); #1;
    checks++;
    if (pass2 !== 1'b0 || tout2 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got pass=%b to=%b want 0/1", pass2, tout2);
    end
    drop2 = 1'b0;
  endtask

  task automatic test_reset_no_restart;
    bit found;
    int r0;
    found = 1'b0;
    start2 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      if (addr2 && !rd2 && busy2) begin
        found = 1'b1;
        break;
      end
    end
    rst2 = 1'b1;
    #1;
    checks++;
    if (!found || rd2 !== 1'b0 || busy2 !== 1'b0 || pass2 !== 1'b0 || tout2 !== 1'b0) begin
      errors++;
      $display("FAIL reset2_mid: got found=%b rd=%b busy=%b pass=%b to=%b want 1/0/0/0/0",
               found, rd2, busy2, pass2, tout2);
    end
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    r0 = rd2_0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (busy2 !== 1'b0 || rd2_0 !== r0) begin
      errors++;
      $display("FAIL reset2_no_restart: got busy=%b new_reads=%0d want 0/0", busy2, rd2_0 - r0);
    end
  endtask

  initial begin
    test_reset();
    test_autostart();
    test_bad_ts();
    test_stall();
    test_zero_latency();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_reset_no_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
